// File: rtl/stream_mux_rr.sv
// ============================================================================
// Module   : stream_mux_rr
// Summary  : N-input registered stream mux with valid/ready handshakes,
//            explicit-select or round-robin channel selection.
//            Optional transfer counter enabled by macro MUX_XFER_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_mux_rr #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_chan,
  output logic [15:0]             xfer_cnt
);

  localparam int         NUM_PAD = 1 << SEL_W;
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_chan;
  logic [SEL_W-1:0] r_last_grant;

  logic [NUM_PAD-1:0] w_valid_pad;
  logic               w_sel_grant;
  logic               w_rr_grant;
  logic [SEL_W-1:0]   w_rr_idx;
  logic               w_grant;
  logic [SEL_W-1:0]   w_gnt_idx;
  logic [WIDTH-1:0]   w_gnt_data;
  logic               w_load_en;
  int                 w_cand;

  // Padding lets an out-of-range sel index safely; padded bits are zero.
  assign w_valid_pad = NUM_PAD'(in_valid);
  assign w_sel_grant = (int'(sel) < NUM_IN) && w_valid_pad[sel];

  // Scan downward so the closest channel after last_grant is assigned last.
  always_comb begin
    w_rr_grant = 1'b0;
    w_rr_idx   = '0;
    w_cand     = 0;
    for (int k = NUM_IN; k >= 1; k--) begin
      w_cand = int'(r_last_grant) + k;
      if (w_cand >= NUM_IN) w_cand = w_cand - NUM_IN;
      if (w_valid_pad[SEL_W'(w_cand)]) begin
        w_rr_grant = 1'b1;
        w_rr_idx   = SEL_W'(w_cand);
      end
    end
  end

  assign w_grant   = mode ? w_rr_grant : w_sel_grant;
  assign w_gnt_idx = mode ? w_rr_idx : sel;
  assign w_load_en = (r_state == S_EMPTY) || out_ready;

  always_comb begin
    in_ready   = '0;
    w_gnt_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_gnt_idx == SEL_W'(i)) begin
        in_ready[i] = w_load_en && w_grant;
        w_gnt_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Explicit-select transfers leave the round-robin pointer untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_data       <= '0;
      r_chan       <= '0;
      r_last_grant <= SEL_W'(NUM_IN - 1);
    end else if (w_load_en) begin
      r_state <= w_grant ? S_FULL : S_EMPTY;
      if (w_grant) begin
        r_data <= w_gnt_data;
        r_chan <= w_gnt_idx;
        if (mode) r_last_grant <= w_gnt_idx;
      end
    end
  end

  assign out_valid = (r_state == S_FULL);
  assign out_data  = r_data;
  assign out_chan  = r_chan;

`ifdef MUX_XFER_CNT_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= 16'h0000;
    end else if (out_valid && out_ready && (r_xfer_cnt != 16'hFFFF)) begin
      r_xfer_cnt <= r_xfer_cnt + 16'h0001;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`else
  assign xfer_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
// ============================================================================
// Module   : tb_stream_mux_rr
// Summary  : Self-checking bench for stream_mux_rr (vector table, directed
//            corner sequences, randomized run against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_mux_rr;

  localparam int W = 5;
  localparam int N = 4;
`ifdef MUX_XFER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode, out_ready, out_valid;
  logic [1:0]    sel, out_chan;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid, in_ready;
  logic [W-1:0]  out_data;
  logic [15:0]   xfer_cnt;

  logic          mode3, out_ready3, out_valid3;
  logic [1:0]    sel3, out_chan3;
  logic [3*W-1:0] in_data3;
  logic [2:0]    in_valid3, in_ready3;
  logic [W-1:0]  out_data3;
  logic [15:0]   xfer_cnt3;

  int checks = 0;
  int errors = 0;

  stream_mux_rr #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan), .xfer_cnt(xfer_cnt)
  );

  stream_mux_rr #(.WIDTH(W), .NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_chan(out_chan3), .xfer_cnt(xfer_cnt3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         mode;
    logic [1:0]   sel;
    logic [N-1:0] valid;
    logic [N*W-1:0] data;
    logic         rdy;
    logic [N-1:0] exp_ready;
    logic         exp_ov;
    logic [W-1:0] exp_od;
    logic [1:0]   exp_oc;
  } vec_t;

  localparam logic [N*W-1:0] DA = {5'h03, 5'h15, 5'h01, 5'h00};
  localparam logic [N*W-1:0] DB = {5'h13, 5'h12, 5'h11, 5'h10};

  vec_t tbl[10];

  // Reference model state
  bit          m_valid;
  logic [W-1:0] m_data;
  int          m_chan, m_lg, m_cnt;
  int          order[$];
  bit          m_load, m_g;
  int          m_gi;
  logic [N-1:0] m_exp_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic m, input logic [1:0] s, input logic [N-1:0] v,
                       input logic [N*W-1:0] d, input logic r);
    mode = m; sel = s; in_valid = v; in_data = d; out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b0, 2'd2, 4'b1111, DA, 1'b1, 4'b0100, 1'b1, 5'h15, 2'd2};
    tbl[1] = '{1'b1, 2'd0, 4'b1111, DB, 1'b1, 4'b0001, 1'b1, 5'h10, 2'd0};
    tbl[2] = '{1'b1, 2'd0, 4'b1010, DB, 1'b1, 4'b0010, 1'b1, 5'h11, 2'd1};
    tbl[3] = '{1'b1, 2'd0, 4'b1010, DB, 1'b0, 4'b0000, 1'b1, 5'h11, 2'd1};
    tbl[4] = '{1'b1, 2'd0, 4'b1010, DB, 1'b1, 4'b1000, 1'b1, 5'h13, 2'd3};
    tbl[5] = '{1'b1, 2'd0, 4'b0000, DB, 1'b1, 4'b0000, 1'b0, 5'h00, 2'd0};
    tbl[6] = '{1'b0, 2'd1, 4'b0001, DB, 1'b0, 4'b0000, 1'b0, 5'h00, 2'd0};
    tbl[7] = '{1'b0, 2'd1, 4'b0010, DB, 1'b0, 4'b0010, 1'b1, 5'h11, 2'd1};
    tbl[8] = '{1'b0, 2'd0, 4'b1111, DB, 1'b0, 4'b0000, 1'b1, 5'h11, 2'd1};
    tbl[9] = '{1'b1, 2'd0, 4'b0001, DB, 1'b1, 4'b0001, 1'b1, 5'h10, 2'd0};

    rst_n = 1'b0;
    drive(1'b0, 2'd0, '0, '0, 1'b0);
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 15'h5A5A; out_ready3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", {27'd0, out_data}, 32'd0);
    chk("reset_out_chan", {30'd0, out_chan}, 32'd0);
    chk("reset_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    rst_n = 1'b1;

    // Out-of-range select on a 3-channel instance
    for (int c = 0; c < 5; c++) begin
      #3;
      chk("badsel_in_ready", {29'd0, in_ready3}, 32'd0);
      tick();
      chk("badsel_out_valid", {31'd0, out_valid3}, 32'd0);
    end

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].mode, tbl[i].sel, tbl[i].valid, tbl[i].data, tbl[i].rdy);
      #3;
      chk($sformatf("vec%0d_in_ready", i), {28'd0, in_ready}, {28'd0, tbl[i].exp_ready});
      tick();
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_ov});
      if (tbl[i].exp_ov) begin
        chk($sformatf("vec%0d_out_data", i), {27'd0, out_data}, {27'd0, tbl[i].exp_od});
        chk($sformatf("vec%0d_out_chan", i), {30'd0, out_chan}, {30'd0, tbl[i].exp_oc});
      end
    end

    // Round-robin fairness with all channels valid
    pulse_reset();
    drive(1'b1, 2'd0, 4'b1111, DB, 1'b1);
    for (int k = 0; k < 8; k++) begin
      #3;
      chk("rr_in_ready", {28'd0, in_ready}, 32'd1 << (k % N));
      tick();
      chk("rr_out_valid", {31'd0, out_valid}, 32'd1);
      chk("rr_out_chan", {30'd0, out_chan}, k % N);
      chk("rr_out_data", {27'd0, out_data}, {27'd0, DB[(k % N)*W +: W]});
    end

    // Backpressure hold followed by same-cycle reload
    pulse_reset();
    drive(1'b1, 2'd0, 4'b0010, {5'h1C, 5'h1B, 5'h0A, 5'h19}, 1'b1);
    #3;
    chk("bp_first_in_ready", {28'd0, in_ready}, 32'b0010);
    tick();
    drive(1'b1, 2'd0, 4'b1111, {5'h1C, 5'h1B, 5'h0A, 5'h19}, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("bp_hold_in_ready", {28'd0, in_ready}, 32'd0);
      tick();
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_chan", {30'd0, out_chan}, 32'd1);
      chk("bp_hold_data", {27'd0, out_data}, 32'h0A);
    end
    out_ready = 1'b1;
    #3;
    chk("bp_release_in_ready", {28'd0, in_ready}, 32'b0100);
    tick();
    chk("bp_release_chan", {30'd0, out_chan}, 32'd2);
    chk("bp_release_data", {27'd0, out_data}, 32'h1B);

    // Asynchronous reset while the output register is full
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_data", {27'd0, out_data}, 32'd0);
    chk("async_rst_chan", {30'd0, out_chan}, 32'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 2'd0, 4'b1111, DB, 1'b1);
    #3;
    chk("post_rst_in_ready", {28'd0, in_ready}, 32'b0001);
    tick();
    chk("post_rst_chan", {30'd0, out_chan}, 32'd0);

    // Randomized run against the reference model
    pulse_reset();
    m_valid = 1'b0; m_data = '0; m_chan = 0; m_lg = N - 1; m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
            20'($urandom), ($urandom_range(0, 3) != 0));
      #3;
      m_load = !m_valid || out_ready;
      m_g = 1'b0;
      m_gi = 0;
      if (!mode) begin
        m_g = in_valid[sel];
        m_gi = int'(sel);
      end else begin
        order.delete();
        for (int k = 0; k < N; k++) order.push_back((m_lg + 1 + k) % N);
        foreach (order[j]) begin
          if (!m_g && in_valid[order[j]]) begin
            m_g = 1'b1;
            m_gi = order[j];
          end
        end
      end
      m_exp_ready = (m_load && m_g) ? 4'(1 << m_gi) : 4'd0;
      chk("rnd_in_ready", {28'd0, in_ready}, {28'd0, m_exp_ready});
      if (CNT_EN && m_valid && out_ready && m_cnt < 65535) m_cnt++;
      if (m_load) begin
        m_valid = m_g;
        if (m_g) begin
          m_data = in_data[m_gi*W +: W];
          m_chan = m_gi;
          if (mode) m_lg = m_gi;
        end
      end
      tick();
      chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("rnd_out_data", {27'd0, out_data}, {27'd0, m_data});
        chk("rnd_out_chan", {30'd0, out_chan}, m_chan);
      end
      chk("rnd_xfer_cnt", {16'd0, xfer_cnt}, m_cnt);
    end

`ifdef MUX_XFER_CNT_EN
    drive(1'b1, 2'd0, 4'b1111, DB, 1'b1);
    repeat (70000) @(posedge clk);
    #1;
    chk("cnt_saturate", {16'd0, xfer_cnt}, 32'hFFFF);
    repeat (5) tick();
    chk("cnt_saturate_hold", {16'd0, xfer_cnt}, 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
